// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared definitions for the ALU execute unit:
//   - ALU_* operation encodings produced by the ALU decoder
//   - default operand width
//   - execute-unit FSM state encoding
//   - small helper to classify shift operations
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_NONE             = 4'd0;
    localparam logic [3:0] ALU_SHIFTL           = 4'd1;
    localparam logic [3:0] ALU_ADD              = 4'd2;
    localparam logic [3:0] ALU_SUB              = 4'd3;
    localparam logic [3:0] ALU_LESS_THAN        = 4'd4;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd5;
    localparam logic [3:0] ALU_SHIFTR           = 4'd6;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd7;
    localparam logic [3:0] ALU_XOR              = 4'd8;
    localparam logic [3:0] ALU_OR               = 4'd9;
    localparam logic [3:0] ALU_AND              = 4'd10;
    localparam logic [3:0] ALU_COPY_B           = 4'd11;

    typedef enum logic [1:0] {
        ALU_EXEC_IDLE  = 2'd0,
        ALU_EXEC_SHIFT = 2'd1,
        ALU_EXEC_DONE  = 2'd2
    } exec_state_t;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SHIFTL) || (code == ALU_SHIFTR) ||
               (code == ALU_SHIFTR_ARITH);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// ---------------------------------------------------------------------------
// alu_comb_core
// Purely combinational single-cycle ALU datapath.
//
// Configuration macro: ALU_BARREL_SHIFT_EN
//   defined   : shift codes are evaluated with a barrel shifter here.
//   undefined : shift codes return operand a unchanged (the shift-by-zero
//               result); non-zero shifts are done iteratively by the caller.
//
// Ports:
//   alu_control  in   4     operation code (ALU_* encodings)
//   a            in   XLEN  operand A
//   b            in   XLEN  operand B (low SHAMT_W bits = shift amount)
//   y            out  XLEN  result
// ---------------------------------------------------------------------------
module alu_comb_core
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no code path leaves y unassigned and infers a latch.
        y = '0;
        case (alu_control)
            ALU_ADD:              y = a + b;
            ALU_SUB:              y = a - b;
            ALU_XOR:              y = a ^ b;
            ALU_OR:               y = a | b;
            ALU_AND:              y = a & b;
            ALU_LESS_THAN_SIGNED: y = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_LESS_THAN:        y = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_COPY_B:           y = b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SHIFTL:           y = a << b[SHAMT_W-1:0];
            ALU_SHIFTR:           y = a >> b[SHAMT_W-1:0];
            ALU_SHIFTR_ARITH:     y = $signed(a) >>> b[SHAMT_W-1:0];
`else
            ALU_SHIFTL,
            ALU_SHIFTR,
            ALU_SHIFTR_ARITH:     y = a;
`endif
            default:              y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Sequential ALU execute unit with valid/ready handshakes on both sides.
// Non-shift ops finish in one cycle; shifts by a non-zero amount step one
// bit per cycle (latency shamt+1) unless the barrel shifter is built.
// One operation in flight at a time.
//
// Configuration macro: ALU_BARREL_SHIFT_EN
//   defined   : all ops, including shifts, have latency 1; the SHIFT state,
//               working register and counter are not built.
//   undefined : iterative one-bit-per-cycle shifter.
//
// Ports:
//   clk          in   1     system clock
//   rst          in   1     synchronous active-high reset
//   in_valid     in   1     operation request valid
//   in_ready     out  1     unit can accept a request (state == IDLE)
//   alu_control  in   4     operation code (ALU_* encodings)
//   src_a        in   XLEN  operand A
//   src_b        in   XLEN  operand B; shift amount = src_b[SHAMT_W-1:0]
//   out_valid    out  1     result valid (state == DONE)
//   out_ready    in   1     consumer accepts result
//   result       out  XLEN  registered result
//   zero         out  1     result == 0, registered with result
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    exec_state_t     state;
    exec_state_t     state_next;
    logic            accept;
    logic            take_direct;   // accepted op finishes in one cycle
    logic [XLEN-1:0] core_y;

    assign accept = in_valid & in_ready;

    alu_comb_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .alu_control (alu_control),
        .a           (src_a),
        .b           (src_b),
        .y           (core_y)
    );

`ifdef ALU_BARREL_SHIFT_EN
    assign take_direct = accept;
`else
    logic [SHAMT_W-1:0] shamt;
    logic               start_shift;
    logic [3:0]         op_q;
    logic [XLEN-1:0]    work_q;
    logic [XLEN-1:0]    work_step;
    logic [SHAMT_W-1:0] count_q;
    logic               last_step;

    assign shamt       = src_b[SHAMT_W-1:0];
    assign start_shift = accept && is_shift_op(alu_control) && (shamt != '0);
    // A shift by zero takes the single-cycle path: the core returns src_a.
    assign take_direct = accept && !start_shift;
    assign last_step   = (count_q == SHAMT_W'(1));

    // One-bit step of the latched shift direction.
    always_comb begin
        work_step = work_q;
        case (op_q)
            ALU_SHIFTL: work_step = {work_q[XLEN-2:0], 1'b0};
            ALU_SHIFTR: work_step = {1'b0, work_q[XLEN-1:1]};
            default:    work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    // NOTE: the shift working register, counter and latched opcode carry no
    // reset: they are always loaded on the accept that enters SHIFT before
    // being read, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (start_shift) begin
            work_q  <= src_a;
            count_q <= shamt;
            op_q    <= alu_control;
        end else if (state == ALU_EXEC_SHIFT) begin
            work_q  <= work_step;
            count_q <= count_q - SHAMT_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= ALU_EXEC_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ALU_EXEC_IDLE: begin
`ifdef ALU_BARREL_SHIFT_EN
                if (accept) state_next = ALU_EXEC_DONE;
`else
                if (start_shift)      state_next = ALU_EXEC_SHIFT;
                else if (take_direct) state_next = ALU_EXEC_DONE;
`endif
            end
`ifndef ALU_BARREL_SHIFT_EN
            ALU_EXEC_SHIFT: begin
                if (last_step) state_next = ALU_EXEC_DONE;
            end
`endif
            ALU_EXEC_DONE: begin
                if (out_ready) state_next = ALU_EXEC_IDLE;
            end
            default: state_next = ALU_EXEC_IDLE;
        endcase
    end

    // Handshake outputs are decoded straight from the state.
    always_comb begin
        in_ready  = (state == ALU_EXEC_IDLE);
        out_valid = (state == ALU_EXEC_DONE);
    end

    // Result and zero flag; held unchanged outside the two load points.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
        end else if (take_direct) begin
            result <= core_y;
            zero   <= (core_y == '0);
        end
`ifndef ALU_BARREL_SHIFT_EN
        else if ((state == ALU_EXEC_SHIFT) && last_step) begin
            result <= work_step;
            zero   <= (work_step == '0);
        end
`endif
    end

endmodule
